// File: rtl/clock_time_keeper.sv
`default_nettype none
// ============================================================================
//  Module   : clock_time_keeper
//  Function : Resynchronises the board 1 Hz square wave, detects its rising
//             edge and drives a 24-hour BCD HH:MM:SS counter with set/clear
//             controls from the push-button logic.
//  Revision : 1.0  initial release
// ============================================================================
module clock_time_keeper (
    input  logic       in_50MHz,
    input  logic       rst,
    input  logic       in_1Hz,
    input  logic       run_en,
    input  logic       set_min,
    input  logic       set_hour,
    input  logic       clr_sec,
    output logic [3:0] sec_lo,
    output logic [3:0] sec_hi,
    output logic [3:0] min_lo,
    output logic [3:0] min_hi,
    output logic [3:0] hr_lo,
    output logic [3:0] hr_hi,
    output logic       tick_1s,
    output logic       day_wrap
);

    logic       r_s1, r_s2, r_s3;
    // r_v1/r_v2 follow the synchroniser and mark when s2 holds a real sample
    // of in_1Hz rather than the value forced by reset, so a wave that is
    // already high at reset release cannot arm the edge detector.
    logic       r_v1, r_v2;
    logic       r_armed;
    logic       w_edge;
    logic       w_tick;

    logic [8:0] w_sec_inc, w_min_inc;
    logic [3:0] w_sec_lo_nx, w_sec_hi_nx, w_min_lo_nx, w_min_hi_nx;
    logic [3:0] w_hr_lo_nx, w_hr_hi_nx;
    logic       w_sec_carry, w_min_carry, w_hr_step, w_wrap;

    // Increment a 00..59 BCD pair; returns {carry, hi, lo}.
    function automatic logic [8:0] inc60(input logic [3:0] hi, input logic [3:0] lo);
        logic [8:0] res;
        if (lo >= 4'd9) begin
            if (hi >= 4'd5) res = {1'b1, 4'd0, 4'd0};
            else            res = {1'b0, hi + 4'd1, 4'd0};
        end else begin
            res = {1'b0, hi, lo + 4'd1};
        end
        return res;
    endfunction

    // Three-stage resynchroniser plus arming of the rising-edge detector.
    always_ff @(posedge in_50MHz) begin
        if (rst) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_s3    <= 1'b0;
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_s1 <= in_1Hz;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
            r_v1 <= 1'b1;
            r_v2 <= r_v1;
            if (r_v2 && !r_s2) r_armed <= 1'b1;
        end
    end

    assign w_edge    = r_s2 & ~r_s3 & r_armed;
    assign w_tick    = w_edge & run_en;
    assign w_sec_inc = inc60(sec_hi, sec_lo);
    assign w_min_inc = inc60(min_hi, min_lo);

    // Next-state of the cascade; set/clear pulses override the tick carry per field.
    always_comb begin
        w_sec_lo_nx = sec_lo;
        w_sec_hi_nx = sec_hi;
        w_sec_carry = 1'b0;
        w_min_lo_nx = min_lo;
        w_min_hi_nx = min_hi;
        w_min_carry = 1'b0;
        w_hr_lo_nx  = hr_lo;
        w_hr_hi_nx  = hr_hi;
        w_wrap      = 1'b0;

        if (clr_sec) begin
            w_sec_lo_nx = 4'd0;
            w_sec_hi_nx = 4'd0;
        end else if (w_tick) begin
            {w_sec_carry, w_sec_hi_nx, w_sec_lo_nx} = w_sec_inc;
        end

        if (set_min || w_sec_carry) begin
            w_min_hi_nx = w_min_inc[7:4];
            w_min_lo_nx = w_min_inc[3:0];
            w_min_carry = w_min_inc[8] & ~set_min;
        end

        w_hr_step = set_hour | w_min_carry;
        if (w_hr_step) begin
            if (hr_hi >= 4'd2 && hr_lo >= 4'd3) begin
                w_hr_hi_nx = 4'd0;
                w_hr_lo_nx = 4'd0;
                w_wrap     = ~set_hour;
            end else if (hr_lo >= 4'd9) begin
                w_hr_hi_nx = hr_hi + 4'd1;
                w_hr_lo_nx = 4'd0;
            end else begin
                w_hr_lo_nx = hr_lo + 4'd1;
            end
        end
    end

    // Registered digits and one-cycle status pulses.
    always_ff @(posedge in_50MHz) begin
        if (rst) begin
            sec_lo   <= 4'd0;
            sec_hi   <= 4'd0;
            min_lo   <= 4'd0;
            min_hi   <= 4'd0;
            hr_lo    <= 4'd0;
            hr_hi    <= 4'd0;
            tick_1s  <= 1'b0;
            day_wrap <= 1'b0;
        end else begin
            sec_lo   <= w_sec_lo_nx;
            sec_hi   <= w_sec_hi_nx;
            min_lo   <= w_min_lo_nx;
            min_hi   <= w_min_hi_nx;
            hr_lo    <= w_hr_lo_nx;
            hr_hi    <= w_hr_hi_nx;
            tick_1s  <= w_edge;
            day_wrap <= w_wrap;
        end
    end

endmodule
`default_nettype wire
